// File: rtl/rob_redirect_ctrl.sv
// Redirect controller inside the reorder buffer: turns commit-time mispredicts and traps
// into a PC redirect pulse, a tagged-entry flush window and a tag-clear pulse.
module rob_redirect_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid,
   input  logic             br_mispredict,
   input  logic [31:0]      br_target,
   output logic             br_ready,
   input  logic             trap_valid,
   input  logic [31:0]      trap_address,
   output logic             trap_ready,
   output logic [31:0]      jump_address,
   output logic             wr,
   output logic             delete_tagged,
   output logic             clear_tags,
   output logic             stall_commit,
   output logic [CNT_W-1:0] mispredict_count
);

   typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state;
   logic [3:0]  flush_cnt;
   logic        trap_take;
   logic        br_take;
   logic        redirect;
   logic [31:0] redirect_target;

   // A trap outranks a branch presented in the same cycle; the branch simply waits.
   assign trap_ready      = (state == IDLE);
   assign br_ready        = (state == IDLE) && !trap_valid;
   assign trap_take       = trap_valid && trap_ready;
   assign br_take         = br_valid && br_ready;
   assign redirect        = trap_take || (br_take && br_mispredict);
   assign redirect_target = trap_take ? trap_address : br_target;

   // wr and clear_tags default low each cycle so they can only ever be one-cycle pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         flush_cnt        <= '0;
         jump_address     <= '0;
         wr               <= 1'b0;
         delete_tagged    <= 1'b0;
         clear_tags       <= 1'b0;
         stall_commit     <= 1'b0;
         mispredict_count <= '0;
      end else begin
         wr         <= 1'b0;
         clear_tags <= 1'b0;
         case (state)
            IDLE: begin
               if (redirect) begin
                  state         <= FLUSH;
                  wr            <= 1'b1;
                  jump_address  <= redirect_target & ~32'h3;
                  delete_tagged <= 1'b1;
                  stall_commit  <= 1'b1;
                  flush_cnt     <= FLUSH_LOAD;
                  if (mispredict_count != '1)
                     mispredict_count <= mispredict_count + CNT_W'(1);
               end else if (br_take) begin
                  clear_tags <= 1'b1;
               end
            end
            FLUSH: begin
               if (flush_cnt == 4'd0) begin
                  state         <= RECOVER;
                  delete_tagged <= 1'b0;
                  clear_tags    <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            RECOVER: begin
               state        <= IDLE;
               stall_commit <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rob_redirect_ctrl.sv
// Scoreboard bench for rob_redirect_ctrl: a timeline model predicts each wr/clear_tags
// pulse and the flush/stall windows; a negedge monitor pops and compares.
module tb_rob_redirect_ctrl;

   localparam int FC      = 2;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct {
      int          cyc;
      bit          is_wr;
      logic [31:0] addr;
      int          cnt;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          br_valid = 1'b0;
   logic          br_mispredict = 1'b0;
   logic [31:0]   br_target = '0;
   logic          br_ready;
   logic          trap_valid = 1'b0;
   logic [31:0]   trap_address = '0;
   logic          trap_ready;
   logic [31:0]   jump_address;
   logic          wr;
   logic          delete_tagged;
   logic          clear_tags;
   logic          stall_commit;
   logic [CW-1:0] mispredict_count;

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   ev_t sb[$];

   // Reference model state: when the controller is next free, when the last redirect landed.
   int          free_at = 0;
   int          last_acc = -1000;
   int          m_cnt = 0;
   logic [31:0] seen_jump = '0;

   // Requests held by their sources until accepted.
   logic        p_bv = 1'b0, p_bm = 1'b0, p_tv = 1'b0;
   logic [31:0] p_bt = '0, p_ta = '0;

   rob_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .br_valid(br_valid), .br_mispredict(br_mispredict), .br_target(br_target),
      .br_ready(br_ready),
      .trap_valid(trap_valid), .trap_address(trap_address), .trap_ready(trap_ready),
      .jump_address(jump_address), .wr(wr), .delete_tagged(delete_tagged),
      .clear_tags(clear_tags), .stall_commit(stall_commit),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Present pending requests for one cycle, predict what the controller does with them.
   task automatic applyStimulus();
      bit idle, t_acc, b_acc;
      int a;
      br_valid      = p_bv;
      br_mispredict = p_bm;
      br_target     = p_bt;
      trap_valid    = p_tv;
      trap_address  = p_ta;
      #1;
      idle  = (cyc >= free_at);
      t_acc = p_tv && idle;
      b_acc = p_bv && idle && !p_tv;
      checkOutput("trap_ready", trap_ready, idle);
      checkOutput("br_ready", br_ready, idle && !p_tv);
      a = cyc + 1;
      if (t_acc || (b_acc && p_bm)) begin
         m_cnt    = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         last_acc = a;
         free_at  = a + FC + 1;
         sb.push_back('{a, 1'b1, (t_acc ? p_ta : p_bt) & ~32'h3, m_cnt});
         sb.push_back('{a + FC, 1'b0, 32'h0, 0});
      end else if (b_acc) begin
         sb.push_back('{a, 1'b0, 32'h0, 0});
      end
      if (t_acc) p_tv = 1'b0;
      if (b_acc) p_bv = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic stepCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic setBranch(input logic mis, input logic [31:0] tgt);
      p_bv = 1'b1; p_bm = mis; p_bt = tgt;
   endtask

   task automatic setTrap(input logic [31:0] adr);
      p_tv = 1'b1; p_ta = adr;
   endtask

   // Monitor: every pulse must match the head of the scoreboard, in the predicted cycle.
   always @(negedge clk) begin
      if (reset) begin
         seen_jump = '0;
      end else begin
         if (wr || clear_tags) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_pulse", {30'd0, wr, clear_tags}, 32'd0);
            end else begin
               ev_t e;
               e = sb.pop_front();
               checkOutput("pulse_cycle", cyc, e.cyc);
               checkOutput("wr_pulse", wr, e.is_wr);
               checkOutput("clear_tags_pulse", clear_tags, !e.is_wr);
               if (e.is_wr) begin
                  checkOutput("jump_address_at_wr", jump_address, e.addr);
                  checkOutput("mispredict_count", mispredict_count, e.cnt);
                  seen_jump = e.addr;
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checkOutput("missing_pulse_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         checkOutput("delete_tagged", delete_tagged,
                     (cyc >= last_acc) && (cyc <= last_acc + FC - 1));
         checkOutput("stall_commit", stall_commit,
                     (cyc >= last_acc) && (cyc <= last_acc + FC));
         checkOutput("jump_address_hold", jump_address, seen_jump);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_jump_address", jump_address, 32'h0);
      checkOutput("reset_count", mispredict_count, 32'h0);
      reset = 1'b0;
      free_at = cyc;
      stepCycles(2);

      // Three back-to-back correct branches.
      for (int i = 0; i < 3; i++) begin
         setBranch(1'b0, 32'h40 + 32'(i));
         applyStimulus();
      end
      stepCycles(2);

      // Single mispredict with an unaligned target.
      setBranch(1'b1, 32'h0000_1237);
      stepCycles(FC + 4);

      // Trap and mispredict together: trap first, branch waits for IDLE.
      setTrap(32'h8000_0000);
      setBranch(1'b1, 32'h0000_0100);
      stepCycles(2 * FC + 6);

      // Trap arriving mid-flush must be held, not lost.
      setBranch(1'b1, 32'h0000_2000);
      stepCycles(2);
      setTrap(32'h0000_0abc);
      stepCycles(2 * FC + 6);

      // Asynchronous reset in the middle of a flush.
      setBranch(1'b1, 32'h0000_3000);
      applyStimulus();
      #1;
      reset = 1'b1;
      #1;
      checkOutput("reset_async_wr", wr, 1'b0);
      checkOutput("reset_async_delete", delete_tagged, 1'b0);
      checkOutput("reset_async_stall", stall_commit, 1'b0);
      checkOutput("reset_async_clear", clear_tags, 1'b0);
      checkOutput("reset_async_jump", jump_address, 32'h0);
      checkOutput("reset_async_count", mispredict_count, 32'h0);
      sb.delete();
      p_bv = 1'b0; p_tv = 1'b0;
      br_valid = 1'b0; trap_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      free_at  = cyc;
      last_acc = -1000;
      m_cnt    = 0;
      stepCycles(3);

      // Saturation of the mispredict counter.
      for (int i = 0; i < 17; i++) begin
         setBranch(1'b1, 32'h0001_0000 + 32'(i * 4));
         stepCycles(FC + 2);
      end
      checkOutput("count_saturated", mispredict_count, CNT_MAX);

      // Randomised traffic with held requests.
      for (int i = 0; i < 400; i++) begin
         if (!p_bv && $urandom_range(0, 2) == 0)
            setBranch(1'($urandom_range(0, 1)), $urandom);
         if (!p_tv && $urandom_range(0, 7) == 0)
            setTrap($urandom);
         applyStimulus();
      end

      // Drain: everything issued must eventually be accepted and observed.
      begin
         int budget;
         budget = 200;
         while ((p_bv || p_tv || sb.size() > 0) && budget > 0) begin
            applyStimulus();
            budget--;
         end
         if (budget == 0) checkOutput("drain_timeout", sb.size() + p_bv + p_tv, 32'd0);
      end
      stepCycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
